crypto_key_loader: RTL and testbench

Upstream provisioning stage for the crypto key store. It accepts a byte stream over a valid/ready handshake and assembles the bytes into 16-bit key words, buffering them internally. It then verifies an XOR checksum byte. Only if the checksum matches does it commit the words to the key store as write pulses; afterwards it zeroizes its buffer and optionally locks itself against re-provisioning until reset.

---
 rtl/crypto_key_loader_if.sv | 22 ++
 rtl/crypto_key_loader.sv | 161 ++++++++++++++++
 tb/tb_crypto_key_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/crypto_key_loader_if.sv
// Provisioning byte stream in, key-store write port out.
interface crypto_key_loader_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic [15:0]       key_data;
  logic [ADDR_W-1:0] key_addr;
  logic              key_write_en;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, key_data, key_addr, key_write_en
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, key_data, key_addr, key_write_en
  );
endinterface

// File: rtl/crypto_key_loader.sv
// Assembles a byte stream into 16-bit key words, verifies an XOR checksum,
// then commits the words to the key store and zeroizes the local buffer.
//
// state  | meaning
// IDLE   | waiting for byte 0 of a transaction
// LOAD   | collecting data bytes, then the checksum byte
// CHECK  | one cycle: compare running XOR with checksum byte
// COMMIT | one key-store write per cycle, NUM_WORDS cycles
// LOCKED | sinks bytes and flags them; left only via reset
module crypto_key_loader #(
  parameter int NUM_WORDS         = 1,
  parameter int ADDR_W            = 4,
  parameter bit LOCK_AFTER_COMMIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  crypto_key_loader_if.slave   bus,
  output logic                 busy,
  output logic                 locked,
  output logic                 err_checksum,
  output logic                 err_locked
);

  localparam int CNT_W = $clog2(2*NUM_WORDS+1);
  localparam logic [CNT_W-1:0]  CSUM_IDX  = CNT_W'(2*NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_COMMIT, S_LOCKED
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        xacc;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] widx;
  logic [15:0]       kbuf [NUM_WORDS];

  logic              in_ready_q;
  logic              key_we_q;
  logic [ADDR_W-1:0] key_addr_q;
  logic [15:0]       key_data_q;

  logic [ADDR_W-1:0] widx_inc;
  logic [15:0]       word_next;

  assign widx_inc = widx + ADDR_W'(1);

  // Word mux written as a loop so the array index width never depends on ADDR_W.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      if (ADDR_W'(k) == widx_inc) word_next = kbuf[k];
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.key_write_en = key_we_q;
  assign bus.key_addr     = key_addr_q;
  assign bus.key_data     = key_data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      xacc         <= '0;
      csum         <= '0;
      widx         <= '0;
      for (int k = 0; k < NUM_WORDS; k++) kbuf[k] <= '0;
      in_ready_q   <= 1'b1;
      key_we_q     <= 1'b0;
      key_addr_q   <= '0;
      key_data_q   <= '0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      err_checksum <= 1'b0;
      err_locked   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (bus.abort) begin
            for (int k = 0; k < NUM_WORDS; k++) kbuf[k] <= '0;
            cnt   <= '0;
            xacc  <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (bus.in_valid) begin
            if (state == S_IDLE) err_checksum <= 1'b0;
            busy <= 1'b1;
            if (cnt == CSUM_IDX) begin
              csum       <= bus.in_data;
              in_ready_q <= 1'b0;
              state      <= S_CHECK;
            end else begin
              for (int k = 0; k < NUM_WORDS; k++) begin
                if (cnt == CNT_W'(2*k))   kbuf[k][15:8] <= bus.in_data;
                if (cnt == CNT_W'(2*k+1)) kbuf[k][7:0]  <= bus.in_data;
              end
              xacc  <= xacc ^ bus.in_data;
              cnt   <= cnt + CNT_W'(1);
              state <= S_LOAD;
            end
          end
        end

        S_CHECK: begin
          if (xacc == csum) begin
            widx       <= '0;
            key_we_q   <= 1'b1;
            key_addr_q <= '0;
            key_data_q <= kbuf[0];
            state      <= S_COMMIT;
          end else begin
            for (int k = 0; k < NUM_WORDS; k++) kbuf[k] <= '0;
            cnt          <= '0;
            xacc         <= '0;
            csum         <= '0;
            err_checksum <= 1'b1;
            in_ready_q   <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end

        S_COMMIT: begin
          if (widx == LAST_WORD) begin
            for (int k = 0; k < NUM_WORDS; k++) kbuf[k] <= '0;
            cnt        <= '0;
            xacc       <= '0;
            csum       <= '0;
            widx       <= '0;
            key_we_q   <= 1'b0;
            key_addr_q <= '0;
            key_data_q <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
            locked     <= LOCK_AFTER_COMMIT;
            state      <= LOCK_AFTER_COMMIT ? S_LOCKED : S_IDLE;
          end else begin
            widx       <= widx_inc;
            key_addr_q <= widx_inc;
            key_data_q <= word_next;
          end
        end

        S_LOCKED: begin
          if (bus.in_valid) err_locked <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          in_ready_q <= 1'b1;
          key_we_q   <= 1'b0;
          key_addr_q <= '0;
          key_data_q <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_key_loader.sv
// Directed bench: dut_a locks after commit, dut_b returns to IDLE; both share stimulus.
module tb_crypto_key_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       v;
  logic [7:0] d;
  logic       ab;

  always #5 clk = ~clk;

  crypto_key_loader_if #(.ADDR_W(4)) if_a ();
  crypto_key_loader_if #(.ADDR_W(4)) if_b ();

  assign if_a.in_data = d;  assign if_a.in_valid = v;  assign if_a.abort = ab;
  assign if_b.in_data = d;  assign if_b.in_valid = v;  assign if_b.abort = ab;

  logic busy_a, locked_a, errc_a, errl_a;
  logic busy_b, locked_b, errc_b, errl_b;

  crypto_key_loader #(.NUM_WORDS(2), .ADDR_W(4), .LOCK_AFTER_COMMIT(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave),
    .busy(busy_a), .locked(locked_a), .err_checksum(errc_a), .err_locked(errl_a)
  );

  crypto_key_loader #(.NUM_WORDS(2), .ADDR_W(4), .LOCK_AFTER_COMMIT(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave),
    .busy(busy_b), .locked(locked_b), .err_checksum(errc_b), .err_locked(errl_b)
  );

  typedef struct {
    logic        rstn, v;
    logic [7:0]  d;
    logic        ab;
    logic [25:0] exp;  // {rdy, we, addr[3:0], data[15:0], busy, lock, errc, errl}
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [25:0] obs(bit sel);
    if (sel)
      return {if_b.in_ready, if_b.key_write_en, if_b.key_addr, if_b.key_data,
              busy_b, locked_b, errc_b, errl_b};
    return {if_a.in_ready, if_a.key_write_en, if_a.key_addr, if_a.key_data,
            busy_a, locked_a, errc_a, errl_a};
  endfunction

  function automatic void row(bit rstn, bit vv, logic [7:0] dd, bit abt,
                              bit rdy, bit we, logic [3:0] a, logic [15:0] dat,
                              bit bsy, bit lck, bit ec, bit el);
    vec_t t;
    t.rstn = rstn; t.v = vv; t.d = dd; t.ab = abt;
    t.exp  = {rdy, we, a, dat, bsy, lck, ec, el};
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    v = 1'b1; d = b;
    while (obs(sel)[25] !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (obs(sel)[25] !== 1'b1) chk("send_timeout", 32'(obs(sel)[25]), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_seq(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cs);
    send_byte(sel, b0); send_byte(sel, b1); send_byte(sel, b2);
    send_byte(sel, b3); send_byte(sel, cs);
    v = 1'b0; d = 8'h00;
  endtask

  task automatic wait_we(input bit sel);
    int n = 0;
    while (obs(sel)[24] !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    if (obs(sel)[24] !== 1'b1) chk("we_timeout", 32'(obs(sel)[24]), 32'd1);
  endtask

  task automatic expect_writes(input bit sel, input logic [15:0] w0, input logic [15:0] w1);
    wait_we(sel);
    chk("write0", 32'(obs(sel)[24:4]), 32'({1'b1, 4'd0, w0}));
    @(negedge clk);
    chk("write1", 32'(obs(sel)[24:4]), 32'({1'b1, 4'd1, w1}));
    @(negedge clk);
    chk("write_end", 32'(obs(sel)[24:4]), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; v = 1'b0; d = 8'h00; ab = 1'b0;

    // rstn v  d    ab  rdy we a  data    busy lock errc errl
    // good commit, then byte while locked, then reset
    row(1,1,8'hAB,0, 1,0,0,16'h0000, 0,0,0,0);
    row(1,1,8'hCD,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h12,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h34,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h40,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,0, 0,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,0, 0,1,0,16'hABCD, 1,0,0,0);
    row(1,0,8'h00,0, 0,1,1,16'h1234, 1,0,0,0);
    row(1,1,8'h55,0, 1,0,0,16'h0000, 0,1,0,0);
    row(1,0,8'h00,0, 1,0,0,16'h0000, 0,1,0,1);
    row(0,0,8'h00,0, 1,0,0,16'h0000, 0,1,0,1);
    // bad checksum, then good transaction clears err_checksum
    row(1,1,8'hAB,0, 1,0,0,16'h0000, 0,0,0,0);
    row(1,1,8'hCD,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h12,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h34,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h41,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,0, 0,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'hAB,0, 1,0,0,16'h0000, 0,0,1,0);
    row(1,1,8'hCD,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h12,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h34,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h40,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,0, 0,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,0, 0,1,0,16'hABCD, 1,0,0,0);
    row(1,0,8'h00,0, 0,1,1,16'h1234, 1,0,0,0);
    row(0,0,8'h00,0, 1,0,0,16'h0000, 0,1,0,0);
    // abort mid-load (with a byte offered), abort ignored in CHECK/COMMIT
    row(1,1,8'hAB,0, 1,0,0,16'h0000, 0,0,0,0);
    row(1,1,8'hCD,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h12,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h34,1, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'hAB,0, 1,0,0,16'h0000, 0,0,0,0);
    row(1,1,8'hCD,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h12,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h34,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,1,8'h40,0, 1,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,1, 0,0,0,16'h0000, 1,0,0,0);
    row(1,0,8'h00,1, 0,1,0,16'hABCD, 1,0,0,0);
    row(1,0,8'h00,0, 0,1,1,16'h1234, 1,0,0,0);
    row(0,0,8'h00,0, 1,0,0,16'h0000, 0,1,0,0);
    row(1,0,8'h00,0, 1,0,0,16'h0000, 0,0,0,0);

    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), 32'(obs(0)), 32'(tbl[i].exp));
      resetn = tbl[i].rstn; v = tbl[i].v; d = tbl[i].d; ab = tbl[i].ab;
      @(negedge clk);
    end
    v = 1'b0; ab = 1'b0; resetn = 1'b1;

    // reset during the first commit cycle, then re-provision
    send_seq(0, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40);
    wait_we(0);
    chk("commit0_before_reset", 32'(obs(0)[24:4]), 32'({1'b1, 4'd0, 16'hABCD}));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("reset_in_commit", 32'(obs(0)), 32'({1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000}));
    send_seq(0, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40);
    expect_writes(0, 16'hABCD, 16'h1234);
    chk("reprov_locked", 32'(obs(0)), 32'({1'b1, 1'b0, 4'd0, 16'h0000, 4'b0100}));

    // dut_b: byte 77 held across CHECK/COMMIT becomes byte 0 of the next transaction
    send_seq(1, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40);
    v = 1'b1; d = 8'h77;
    chk("hold_check_rdy",   32'({obs(1)[25], obs(1)[3]}), 32'b01);
    @(negedge clk);
    chk("hold_commit0_rdy", 32'({obs(1)[25], obs(1)[24]}), 32'b01);
    @(negedge clk);
    chk("hold_commit1_rdy", 32'({obs(1)[25], obs(1)[24]}), 32'b01);
    @(negedge clk);
    chk("hold_idle", 32'(obs(1)), 32'({1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000}));
    @(negedge clk);
    chk("hold_accepted", 32'({obs(1)[25], obs(1)[3]}), 32'b11);
    send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33); send_byte(1, 8'h77);
    v = 1'b0; d = 8'h00;
    expect_writes(1, 16'h7711, 16'h2233);
    chk("b_idle_after", 32'(obs(1)), 32'({1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
